// File: rtl/mux16_scan_ctrl_if.sv
// Handshake and data bundle between the scan sequencer, its host and the 16:1 mux.
// The host side also models the mux output; the sequencer drives select and results.
interface mux16_scan_ctrl_if;
    logic        start;
    logic        single;
    logic [3:0]  addr_in;
    logic        abort;
    logic        mux_q;
    logic [3:0]  sel;
    logic        busy;
    logic        bit_valid;
    logic        bit_out;
    logic [3:0]  bit_idx;
    logic [15:0] word_out;
    logic        done;

    modport master (
        output start, single, addr_in, abort, mux_q,
        input  sel, busy, bit_valid, bit_out, bit_idx, word_out, done
    );

    modport slave (
        input  start, single, addr_in, abort, mux_q,
        output sel, busy, bit_valid, bit_out, bit_idx, word_out, done
    );
endinterface

// File: rtl/mux16_scan_ctrl.sv
// Scan sequencer for a 16:1 mux: steps the select, waits a settle time,
// samples the mux output, streams each bit and assembles a 16-bit word.
module mux16_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input logic                  clk,
    input logic                  rst,
    mux16_scan_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state, state_n;
    logic [3:0]       sel_q, sel_n;
    logic [3:0]       last_q, last_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             busy_q, busy_n;
    logic             bv_q, bv_n;
    logic             bit_q, bit_n;
    logic [3:0]       idx_q, idx_n;
    logic [15:0]      word_q, word_n;
    logic             done_q, done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sel_q  <= '0;
            last_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            bv_q   <= 1'b0;
            bit_q  <= 1'b0;
            idx_q  <= '0;
            word_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            sel_q  <= sel_n;
            last_q <= last_n;
            cnt_q  <= cnt_n;
            busy_q <= busy_n;
            bv_q   <= bv_n;
            bit_q  <= bit_n;
            idx_q  <= idx_n;
            word_q <= word_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        last_n  = last_q;
        cnt_n   = cnt_q;
        busy_n  = busy_q;
        bv_n    = 1'b0;
        bit_n   = bit_q;
        idx_n   = idx_q;
        word_n  = word_q;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    word_n  = '0;
                    sel_n   = bus.single ? bus.addr_in : 4'd0;
                    last_n  = bus.single ? bus.addr_in : 4'd15;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                // abort beats a coincident sample point
                if (bus.abort) begin
                    state_n = IDLE;
                    sel_n   = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    bit_n         = bus.mux_q;
                    idx_n         = sel_q;
                    word_n[sel_q] = bus.mux_q;
                    bv_n          = 1'b1;
                    cnt_n         = '0;
                    if (sel_q == last_q) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        sel_n   = '0;
                    end else begin
                        sel_n = sel_q + 4'd1;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.bit_valid = bv_q;
    assign bus.bit_out   = bit_q;
    assign bus.bit_idx   = idx_q;
    assign bus.word_out  = word_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Directed bench for mux16_scan_ctrl with a behavioural 16:1 mux model
// driven from a per-test channel pattern.
module tb_mux16_scan_ctrl;
    logic clk;
    logic rst;
    logic [15:0] pattern;

    int n_checks;
    int n_fail;
    int vcount;
    int dcount;
    int bcount;
    logic [3:0]  idx_seq [16];
    logic [15:0] stream_word;

    mux16_scan_ctrl_if bus ();

    mux16_scan_ctrl #(
        .SETTLE_CYCLES(2),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.mux_q = pattern[bus.sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bit_valid) begin
                if (vcount < 16) idx_seq[vcount] = bus.bit_idx;
                stream_word[bus.bit_idx] = bus.bit_out;
                vcount++;
            end
            if (bus.done) dcount++;
            if (bus.busy) bcount++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        vcount      = 0;
        dcount      = 0;
        bcount      = 0;
        stream_word = '0;
        for (int i = 0; i < 16; i++) idx_seq[i] = 4'hx;
    endtask

    // Pulse start for one edge; returns at the negedge after edge 0.
    task automatic kick(input logic sgl, input logic [3:0] addr);
        bus.start   = 1'b1;
        bus.single  = sgl;
        bus.addr_in = addr;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        pattern     = 16'hA5C3;
        bus.start   = 1'b0;
        bus.single  = 1'b0;
        bus.addr_in = 4'd0;
        bus.abort   = 1'b0;
        clear_mon();
        rst = 1'b1;
        #12;
        check("rst_sel", 32'(bus.sel), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_word", 32'(bus.word_out), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_bv", 32'(bus.bit_valid), 0);
        check("rst_idx", 32'(bus.bit_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_n(2);

        // full scan of 16'hA5C3
        clear_mon();
        kick(1'b0, 4'd0);
        check("full_busy_rise", 32'(bus.busy), 1);
        for (int e = 0; e < 32; e++) begin
            check("full_sel_step", 32'(bus.sel), 32'(e / 2));
            @(negedge clk);
        end
        check("full_done", 32'(bus.done), 1);
        check("full_word", 32'(bus.word_out), 32'hA5C3);
        check("full_last_idx", 32'(bus.bit_idx), 15);
        check("full_sel_back", 32'(bus.sel), 0);
        @(negedge clk);
        check("full_done_pulse", 32'(bus.done), 0);
        wait_n(2);
        check("full_vcount", 32'(vcount), 16);
        check("full_dcount", 32'(dcount), 1);
        check("full_busy_cycles", 32'(bcount), 32);
        check("full_stream", 32'(stream_word), 32'hA5C3);
        for (int i = 0; i < 16; i++)
            check("full_idx_seq", 32'(idx_seq[i]), 32'(i));

        // single channel 9
        pattern = 16'h0200;
        clear_mon();
        kick(1'b1, 4'd9);
        check("sgl_sel0", 32'(bus.sel), 9);
        @(negedge clk);
        check("sgl_sel1", 32'(bus.sel), 9);
        check("sgl_no_done", 32'(bus.done), 0);
        @(negedge clk);
        check("sgl_done", 32'(bus.done), 1);
        check("sgl_bv", 32'(bus.bit_valid), 1);
        check("sgl_idx", 32'(bus.bit_idx), 9);
        check("sgl_bit", 32'(bus.bit_out), 1);
        check("sgl_word", 32'(bus.word_out), 32'h0200);
        wait_n(3);
        check("sgl_vcount", 32'(vcount), 1);
        check("sgl_dcount", 32'(dcount), 1);
        bus.single = 1'b0;

        // abort on the edge sampling channel 4 (edge 10)
        pattern = 16'hA5C3;
        clear_mon();
        kick(1'b0, 4'd0);
        wait_n(9);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abt_busy", 32'(bus.busy), 0);
        check("abt_sel", 32'(bus.sel), 0);
        check("abt_bv", 32'(bus.bit_valid), 0);
        check("abt_word", 32'(bus.word_out), 32'h0003);
        wait_n(5);
        check("abt_dcount", 32'(dcount), 0);
        check("abt_vcount", 32'(vcount), 4);
        check("abt_word_hold", 32'(bus.word_out), 32'h0003);

        // async reset while channel 7 is selected
        clear_mon();
        kick(1'b0, 4'd0);
        wait_n(14);
        check("rmid_sel7", 32'(bus.sel), 7);
        #2 rst = 1'b1;
        #1;
        check("rmid_sel", 32'(bus.sel), 0);
        check("rmid_busy", 32'(bus.busy), 0);
        check("rmid_word", 32'(bus.word_out), 0);
        check("rmid_idx", 32'(bus.bit_idx), 0);
        check("rmid_bit", 32'(bus.bit_out), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_n(2);
        pattern = 16'h3C5A;
        clear_mon();
        kick(1'b0, 4'd0);
        wait_n(32);
        check("rmid_re_done", 32'(bus.done), 1);
        check("rmid_re_word", 32'(bus.word_out), 32'h3C5A);
        wait_n(2);
        check("rmid_re_first", 32'(idx_seq[0]), 0);
        check("rmid_re_vcount", 32'(vcount), 16);

        // start re-pulsed mid-scan is ignored
        pattern = 16'h8001;
        clear_mon();
        kick(1'b0, 4'd0);
        wait_n(10);
        check("rs_sel5", 32'(bus.sel), 5);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("rs_sel_keep", 32'(bus.sel), 5);
        wait_n(21);
        check("rs_done", 32'(bus.done), 1);
        check("rs_word", 32'(bus.word_out), 32'h8001);
        wait_n(3);
        check("rs_dcount", 32'(dcount), 1);
        check("rs_busy_cycles", 32'(bcount), 32);

        // start together with abort in IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        wait_n(2);
        check("sa_busy", 32'(bus.busy), 0);
        check("sa_word", 32'(bus.word_out), 32'h8001);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        wait_n(2);

        // back-to-back scans with start held high
        pattern = 16'h00FF;
        clear_mon();
        bus.start = 1'b1;
        wait_n(33);
        check("b2b_done1", 32'(bus.done), 1);
        check("b2b_word1", 32'(bus.word_out), 32'h00FF);
        pattern = 16'h1234;
        @(negedge clk);
        check("b2b_gap_busy", 32'(bus.busy), 0);
        check("b2b_gap_done", 32'(bus.done), 0);
        @(negedge clk);
        check("b2b_restart", 32'(bus.busy), 1);
        check("b2b_clear", 32'(bus.word_out), 0);
        wait_n(32);
        check("b2b_done2", 32'(bus.done), 1);
        check("b2b_word2", 32'(bus.word_out), 32'h1234);
        bus.start = 1'b0;
        wait_n(4);
        check("b2b_dcount", 32'(dcount), 2);
        check("b2b_idle", 32'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
